// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB bridge and its completers:
//   - FSM state type used by the completers (IDLE, ACCESS)
//   - default bus/storage dimensions
//   - bus phase encodings formed as {PSEL, PENABLE}
// No ports (package).
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int WAIT_W_DEF = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Bus phase as seen on {PSEL, PENABLE}
  localparam logic [1:0] PHASE_IDLE   = 2'b00;
  localparam logic [1:0] PHASE_SETUP  = 2'b10;
  localparam logic [1:0] PHASE_ACCESS = 2'b11;

endpackage

// File: rtl/apb_mem_completer_if.sv
// -----------------------------------------------------------------------------
// apb_mem_completer_if
// APB3 requester/completer signal bundle.
//   master modport: drives PSEL, PENABLE, PWRITE, PADDR, PWDATA;
//                   observes PREADY, PRDATA, PSLVERR
//   slave modport : the mirror image
// -----------------------------------------------------------------------------
interface apb_mem_completer_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_regfile.sv
// -----------------------------------------------------------------------------
// apb_regfile
// DEPTH x DATA_W storage with a per-entry valid bit.
//   clk, rst : clock and asynchronous active-high reset (clears valid bits only)
//   we, waddr, wdata : synchronous write port; sets the entry's valid bit
//   raddr, rdata, rvalid : combinational read port
// Storage contents are not reset; an entry is only meaningful when valid.
// -----------------------------------------------------------------------------
module apb_regfile
  import apb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = $clog2(DEPTH_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  valid_r;

  // Data storage: written on commit, never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Valid tracking: cleared by reset, set by each committed write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else if (we) begin
      valid_r[waddr] <= 1'b1;
    end
  end

  assign rdata  = mem_r[raddr];
  assign rvalid = valid_r[raddr];

endmodule

// File: rtl/apb_mem_completer.sv
// -----------------------------------------------------------------------------
// apb_mem_completer
// APB3 completer serving a small register file with programmable wait states.
//   PCLK        : clock, rising-edge
//   PRESET      : asynchronous active-high reset
//   wait_cycles : wait states to insert, sampled in the SETUP phase
//   apb (slave) : PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PREADY/PRDATA/PSLVERR out
// PSLVERR is raised for out-of-range addresses and for reads of entries that
// were never written since reset. All bus outputs are registered.
// -----------------------------------------------------------------------------
module apb_mem_completer
  import apb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WAIT_W = WAIT_W_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [WAIT_W-1:0] wait_cycles,
  apb_mem_completer_if.slave apb
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable in the range compare
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  apb_state_e        state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              write_r, write_s;
  logic [WAIT_W-1:0] cnt_r, cnt_s;
  logic              pready_r, pready_s;
  logic [DATA_W-1:0] prdata_r, prdata_s;
  logic              pslverr_r, pslverr_s;
  logic              we_s;

  logic [1:0]        phase_s;
  logic [ADDR_W-1:0] rsp_addr_s;
  logic              rsp_write_s;
  logic              rsp_in_range_s;
  logic [DATA_W-1:0] rsp_data_s;
  logic              rsp_err_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              rd_valid_s;

  assign phase_s = {apb.PSEL, apb.PENABLE};

  // Select the transfer the response is built for: a SETUP on the bus wins
  // over the captured one, since it replaces it at the next edge.
  always_comb begin
    rsp_addr_s  = addr_r;
    rsp_write_s = write_r;
    if (phase_s == PHASE_SETUP) begin
      rsp_addr_s  = apb.PADDR;
      rsp_write_s = apb.PWRITE;
    end else begin
      rsp_addr_s  = addr_r;
      rsp_write_s = write_r;
    end
  end

  assign rsp_in_range_s = ({1'b0, rsp_addr_s} < DEPTH_LIM);

  apb_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk    (PCLK),
    .rst    (PRESET),
    .we     (we_s),
    .waddr  (addr_r[IDX_W-1:0]),
    .wdata  (wdata_r),
    .raddr  (rsp_addr_s[IDX_W-1:0]),
    .rdata  (rd_data_s),
    .rvalid (rd_valid_s)
  );

  // Error/read-data decode for the selected transfer
  always_comb begin
    rsp_err_s  = 1'b0;
    rsp_data_s = '0;
    if (rsp_write_s) begin
      rsp_err_s  = ~rsp_in_range_s;
      rsp_data_s = '0;
    end else if (rsp_in_range_s && rd_valid_s) begin
      rsp_err_s  = 1'b0;
      rsp_data_s = rd_data_s;
    end else begin
      rsp_err_s  = 1'b1;
      rsp_data_s = '0;
    end
  end

  // Next-state, capture, wait counting and response generation
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    write_s   = write_r;
    cnt_s     = cnt_r;
    pready_s  = 1'b0;
    prdata_s  = '0;
    pslverr_s = 1'b0;
    we_s      = 1'b0;

    if (phase_s == PHASE_SETUP) begin
      // A SETUP starts a new transfer from either state, abandoning any
      // transfer still in flight.
      state_s = ACCESS;
      addr_s  = apb.PADDR;
      wdata_s = apb.PWDATA;
      write_s = apb.PWRITE;
      cnt_s   = wait_cycles;
      if (wait_cycles == {WAIT_W{1'b0}}) begin
        // Zero-wait: response must already be up in the first ACCESS cycle
        pready_s  = 1'b1;
        prdata_s  = rsp_data_s;
        pslverr_s = rsp_err_s;
      end else begin
        pready_s = 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          // PENABLE without a preceding SETUP is ignored
          state_s = IDLE;
        end
        ACCESS: begin
          if (phase_s == PHASE_ACCESS) begin
            if (pready_r) begin
              // Completion edge: commit a legal write and go idle
              we_s    = write_r & rsp_in_range_s;
              state_s = IDLE;
            end else if (cnt_r <= WAIT_W'(1)) begin
              // Last wait state: raise the response for the next cycle
              cnt_s     = '0;
              pready_s  = 1'b1;
              prdata_s  = rsp_data_s;
              pslverr_s = rsp_err_s;
            end else begin
              cnt_s = cnt_r - WAIT_W'(1);
            end
          end else begin
            // PSEL dropped before completion: abort without a write
            state_s = IDLE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      wdata_r   <= '0;
      write_r   <= 1'b0;
      cnt_r     <= '0;
      pready_r  <= 1'b0;
      prdata_r  <= '0;
      pslverr_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      write_r   <= write_s;
      cnt_r     <= cnt_s;
      pready_r  <= pready_s;
      prdata_r  <= prdata_s;
      pslverr_r <= pslverr_s;
    end
  end

  assign apb.PREADY  = pready_r;
  assign apb.PRDATA  = prdata_r;
  assign apb.PSLVERR = pslverr_r;

endmodule
